// File: rtl/zigzag_pkg.sv
// zigzag_pkg: shared types and walk helper for the zig-zag bit-plane walk.
// Holds the precision-field width, the offset-pair type and next_pos().
package zigzag_pkg;

  localparam int ZZ_BPREC = 4;

  typedef struct packed {
    logic [ZZ_BPREC-1:0] w;
    logic [ZZ_BPREC-1:0] d;
  } off_t;

  // Position that follows (ew, ed) in the diagonal walk for a pw x pd
  // plane grid; the final position (pw-1, pd-1) wraps to (0,0).
  function automatic off_t next_pos(
    input logic [ZZ_BPREC-1:0] pw,
    input logic [ZZ_BPREC-1:0] pd,
    input logic [ZZ_BPREC-1:0] ew,
    input logic [ZZ_BPREC-1:0] ed
  );
    off_t              n;
    logic [ZZ_BPREC:0] k1;
    logic [ZZ_BPREC:0] dd;
    n  = '0;
    k1 = {1'b0, ew} + {1'b0, ed} + 1'b1;
    dd = '0;
    if (ew == pw - 1'b1 && ed == pd - 1'b1) begin
      n = '0;
    end else if (ew == '0 || ed == pd - 1'b1) begin
      if (k1 > {1'b0, pw - 1'b1}) n.w = pw - 1'b1;
      else n.w = k1[ZZ_BPREC-1:0];
      dd  = k1 - {1'b0, n.w};
      n.d = dd[ZZ_BPREC-1:0];
    end else begin
      n.w = ew - 1'b1;
      n.d = ed + 1'b1;
    end
    return n;
  endfunction

endpackage

// File: rtl/zigzag_acc_if.sv
// zigzag_acc_if: term input, product output and precision/sign controls.
// master = term producer, slave = zigzag_acc.
interface zigzag_acc_if
  import zigzag_pkg::*;
#(
  parameter int BPREC = ZZ_BPREC,
  parameter int BPP   = 12,
  parameter int BACC  = 32
);
  logic [BPREC-1:0]      pw;
  logic [BPREC-1:0]      pd;
  logic                  sw;
  logic                  sd;
  logic                  in_valid;
  logic [BPREC-1:0]      in_offw;
  logic [BPREC-1:0]      in_offd;
  logic signed [BPP-1:0] in_pp;
  logic                  out_valid;
  logic [BACC-1:0]       result;
  logic                  seq_err;

  modport master (
    output pw, pd, sw, sd,
    output in_valid, in_offw, in_offd, in_pp,
    input  out_valid, result, seq_err
  );

  modport slave (
    input  pw, pd, sw, sd,
    input  in_valid, in_offw, in_offd, in_pp,
    output out_valid, result, seq_err
  );
endinterface

// File: rtl/zigzag_acc_track.sv
// zigzag_acc_track: expected-position tracker for the diagonal walk.
// Ports: clk, clr, pw, pd, in_valid, tag in; pos, first, last out.
module zigzag_acc_track
  import zigzag_pkg::*;
(
  input  logic                clk,
  input  logic                clr,
  input  logic [ZZ_BPREC-1:0] pw,
  input  logic [ZZ_BPREC-1:0] pd,
  input  logic                in_valid,
  input  off_t                tag,
  output off_t                pos,
  output logic                first,
  output logic                last
);

  assign first = (pos == '0);
  assign last  = (tag.w == pw - 1'b1) && (tag.d == pd - 1'b1);

  // Advance from the received tag so one misplaced term does not
  // cascade into errors on every following term.
  always_ff @(posedge clk) begin
    if (clr) begin
      pos <= '0;
    end else if (in_valid) begin
      pos <= next_pos(pw, pd, tag.w, tag.d);
    end
  end

endmodule

// File: rtl/zigzag_acc.sv
// zigzag_acc: MSB-first shift-accumulate of zig-zag ordered partial products.
// Ports: clk, clr, bus (slave). Option: ZIGZAG_ACC_SIGNED_EN (sign fix-up).
module zigzag_acc
  import zigzag_pkg::*;
#(
  parameter int BPP  = 12,
  parameter int BACC = 32
) (
  input logic         clk,
  input logic         clr,
  zigzag_acc_if.slave bus
);

  localparam int BPREC = ZZ_BPREC;

  off_t                   pos;
  off_t                   tag;
  logic                   first;
  logic                   last;
  logic                   neg;
  logic [BPREC:0]         k_in;
  logic [BPREC:0]         k_prev;
  logic signed [BACC-1:0] pp_ext;
  logic signed [BACC-1:0] t;
  logic signed [BACC-1:0] acc;
  logic signed [BACC-1:0] acc_nxt;

  assign tag = '{w: bus.in_offw, d: bus.in_offd};

  zigzag_acc_track u_track (
    .clk      (clk),
    .clr      (clr),
    .pw       (bus.pw),
    .pd       (bus.pd),
    .in_valid (bus.in_valid),
    .tag      (tag),
    .pos      (pos),
    .first    (first),
    .last     (last)
  );

`ifdef ZIGZAG_ACC_SIGNED_EN
  // MSB planes of signed operands carry negative weight.
  assign neg = (bus.sw && bus.in_offw == '0)
             ^ (bus.sd && bus.in_offd == '0);
`else
  logic unused_sign;
  assign unused_sign = bus.sw | bus.sd;
  assign neg = 1'b0;
`endif

  assign k_in   = {1'b0, bus.in_offw} + {1'b0, bus.in_offd};
  assign pp_ext = BACC'($signed(bus.in_pp));
  assign t      = neg ? -pp_ext : pp_ext;

  always_comb begin
    acc_nxt = acc + t;
    if (first) acc_nxt = t;
    else if (k_in != k_prev) acc_nxt = (acc <<< 1) + t;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      acc        <= '0;
      k_prev     <= '0;
      bus.result    <= '0;
      bus.out_valid <= 1'b0;
      bus.seq_err   <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (bus.in_valid) begin
        acc    <= acc_nxt;
        k_prev <= k_in;
        if (tag != pos) bus.seq_err <= 1'b1;
        if (last) begin
          bus.result    <= acc_nxt;
          bus.out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
